// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multicycle MIPS core.
//   - Memory bridge FSM state encoding and default bus timeout.
//   - ALU operation codes driven by the ALU decoder.
//   - Primary opcode field values decoded by the control FSM.
//   - isWordAligned(): helper used for the access alignment check.
package mips_pkg;

  // Memory bridge FSM
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2,
    MEM_ERR  = 2'd3
  } memState_t;

  localparam int MEM_TIMEOUT_DEFAULT = 15;
  // Wide enough for the full 1..255 timeout range.
  localparam int MEM_WAIT_CNT_W      = 8;

  // ALU operation select
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluOp_t;

  // Instruction opcode field (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: wait-cycle counter for the memory bridge.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - forces the count back to 0 (highest priority after reset)
//   enable      - advance the count by one this cycle
//   tc          - terminal count: high when the count equals TERMINAL-1,
//                 i.e. the cycle in which a further no-ack cycle would make
//                 TERMINAL wait cycles in total.
module timeout_counter #(
  parameter int CNT_W    = 8,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + CNT_W'(1);
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/mips_mem_bridge.sv
// mips_mem_bridge: adapts the multicycle MIPS control FSM's single-cycle
// memory strobes to a req/ack external bus with a bounded wait.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   mem_read, mem_write   - processor request strobes
//   address, write_data   - byte address and store data from the datapath
//   read_data             - registered load result (held until next read)
//   busy                  - stall to the control FSM
//   done, err             - one-cycle completion / failure pulses
//   bus_req/we/addr/wdata - external request, held until ack or timeout
//   bus_rdata, bus_ack    - external response
module mips_mem_bridge
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  memState_t         state, stateNext;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic [31:0]       rdataQ;
  logic              weQ;

  logic anyReq, legalReq, acceptReq;
  logic waitClr, waitEn, waitTc;

  assign anyReq    = mem_read | mem_write;
  assign legalReq  = (mem_read ^ mem_write) && isWordAligned(address[1:0]);
  assign acceptReq = (state == MEM_IDLE) && legalReq;

  // Counter is held at 0 outside REQ so it always starts fresh on entry.
  assign waitClr = (state != MEM_REQ);
  assign waitEn  = (state == MEM_REQ) && !bus_ack;

  timeout_counter #(
    .CNT_W   (MEM_WAIT_CNT_W),
    .TERMINAL(TIMEOUT_CYCLES)
  ) uWait (
    .clk   (clk),
    .reset (reset),
    .clear (waitClr),
    .enable(waitEn),
    .tc    (waitTc)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= MEM_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      MEM_IDLE: begin
        if (legalReq)    stateNext = MEM_REQ;
        else if (anyReq) stateNext = MEM_ERR;  // both strobes or misaligned
      end
      MEM_REQ: begin
        // Ack wins over timeout when both land in the same cycle.
        if (bus_ack)     stateNext = MEM_DONE;
        else if (waitTc) stateNext = MEM_ERR;
      end
      MEM_DONE: stateNext = MEM_IDLE;
      MEM_ERR:  stateNext = MEM_IDLE;
      default:  stateNext = MEM_IDLE;
    endcase
  end

  // Request latches: the bus side sees frozen values for the whole transfer,
  // so datapath muxes may move while we wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      addrQ  <= '0;
      wdataQ <= '0;
      weQ    <= 1'b0;
    end else if (acceptReq) begin
      addrQ  <= {address[ADDR_W-1:2], 2'b00};
      wdataQ <= write_data;
      weQ    <= mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                       rdataQ <= '0;
    else if ((state == MEM_REQ) && bus_ack && !weQ)  rdataQ <= bus_rdata;
  end

  assign bus_req   = (state == MEM_REQ);
  assign bus_we    = (state == MEM_REQ) && weQ;
  assign bus_addr  = addrQ;
  assign bus_wdata = wdataQ;
  assign read_data = rdataQ;
  assign done      = (state == MEM_DONE);
  assign err       = (state == MEM_ERR);
  // Combinational so the control FSM stalls in the very cycle it asks.
  assign busy      = !reset && (((state == MEM_IDLE) && anyReq) || (state == MEM_REQ));

endmodule

// File: tb/tb_mips_mem_bridge.sv
module tb_mips_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        busy, done, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  always #5 clk = ~clk;

  mips_mem_bridge #(.TIMEOUT_CYCLES(15), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  int nChecks = 0;
  int nErrs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: cumulative activity counts sampled on the falling edge.
  int          reqCnt = 0, weCnt = 0, doneCnt = 0, errCnt = 0, stabErr = 0;
  logic [31:0] expAddr = '0, expWdata = '0;
  logic        expWe = 1'b0;

  always @(negedge clk) begin
    if (bus_req) begin
      reqCnt++;
      if (bus_we) weCnt++;
      if (bus_we !== expWe)                 stabErr++;
      if (bus_addr !== expAddr)             stabErr++;
      if (expWe && (bus_wdata !== expWdata)) stabErr++;
    end
    if (done) doneCnt++;
    if (err)  errCnt++;
  end

  int r0, w0, d0, e0, s0;

  task automatic snap();
    r0 = reqCnt; w0 = weCnt; d0 = doneCnt; e0 = errCnt; s0 = stabErr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    address = '0; write_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    tick(); tick();

    // Reset state
    @(negedge clk);
    chk("rst_ctrl", {59'd0, busy, done, err, bus_req, bus_we}, 64'd0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    tick();
    reset = 1'b0;

    // Read, zero wait cycles
    snap(); expAddr = 32'h10; expWe = 1'b0;
    mem_read = 1'b1; address = 32'h10;
    @(negedge clk);
    chk("rd_busy_n", {busy, bus_req}, 2'b10);
    tick();
    mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h8C22_0004;
    @(negedge clk);
    chk("rd_req_n1", {bus_req, bus_we, done}, 3'b100);
    chk("rd_addr", bus_addr, 32'h10);
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rd_done_n2", {done, busy, bus_req, err}, 4'b1000);
    chk("rd_data", read_data, 32'h8C22_0004);
    tick();
    chk("rd_req_cycles", reqCnt - r0, 1);
    chk("rd_done_cnt", doneCnt - d0, 1);
    chk("rd_err_cnt", errCnt - e0, 0);

    // Write, three wait cycles; inputs disturbed mid-transfer
    snap(); expAddr = 32'h100; expWdata = 32'hDEAD_BEEF; expWe = 1'b1;
    mem_write = 1'b1; address = 32'h100; write_data = 32'hDEAD_BEEF;
    tick();
    mem_write = 1'b0; mem_read = 1'b1; address = 32'h4; write_data = 32'h0;
    tick();
    mem_read = 1'b0;
    tick(); tick();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("wr_done", {done, bus_req, bus_we}, 3'b100);
    tick();
    chk("wr_req_cycles", reqCnt - r0, 4);
    chk("wr_we_cycles", weCnt - w0, 4);
    chk("wr_stable", stabErr - s0, 0);
    chk("wr_done_cnt", doneCnt - d0, 1);
    chk("wr_rdata_kept", read_data, 32'h8C22_0004);

    // Misaligned read
    snap();
    mem_read = 1'b1; address = 32'h102;
    tick();
    mem_read = 1'b0;
    @(negedge clk);
    chk("mis_err", {err, bus_req, done}, 3'b100);
    tick();
    @(negedge clk);
    chk("mis_err_gone", {err, busy}, 2'b00);
    tick();
    chk("mis_req_cnt", reqCnt - r0, 0);
    chk("mis_err_cnt", errCnt - e0, 1);

    // Read and write together
    snap();
    mem_read = 1'b1; mem_write = 1'b1; address = 32'h20;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("both_err", {err, bus_req}, 2'b10);
    tick();
    chk("both_req_cnt", reqCnt - r0, 0);
    chk("both_err_cnt", errCnt - e0, 1);

    // Timeout: no ack for a read
    snap(); expAddr = 32'h40; expWe = 1'b0;
    mem_read = 1'b1; address = 32'h40;
    tick();
    mem_read = 1'b0;
    repeat (15) tick();
    @(negedge clk);
    chk("to_err", {err, bus_req, busy}, 3'b100);
    tick();
    @(negedge clk);
    chk("to_idle", {err, bus_req, busy, done}, 4'b0000);
    tick();
    chk("to_req_cycles", reqCnt - r0, 15);
    chk("to_err_cnt", errCnt - e0, 1);
    chk("to_done_cnt", doneCnt - d0, 0);
    chk("to_stable", stabErr - s0, 0);

    // Stray ack in IDLE is ignored
    snap();
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack", {done, err, bus_req}, 3'b000);
    chk("stray_rdata", read_data, 32'h8C22_0004);
    tick();
    chk("stray_done_cnt", doneCnt - d0, 0);

    // Request held through DONE is only taken back in IDLE
    snap(); expAddr = 32'h80; expWe = 1'b0;
    mem_read = 1'b1; address = 32'h80;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hA5A5_0001;
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("b2b_done", {done, busy, bus_req}, 3'b100);
    chk("b2b_rdata1", read_data, 32'hA5A5_0001);
    tick();
    @(negedge clk);
    chk("b2b_idle_busy", {busy, bus_req}, 2'b10);
    tick();
    mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("b2b_req2", bus_req, 1'b1);
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("b2b_rdata2", read_data, 32'h1111_2222);
    tick();
    chk("b2b_done_cnt", doneCnt - d0, 2);
    chk("b2b_stable", stabErr - s0, 0);

    // Reset on the second REQ cycle
    snap(); expAddr = 32'h200; expWe = 1'b0;
    mem_read = 1'b1; address = 32'h200;
    tick();
    mem_read = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rr_req_before", bus_req, 1'b1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rr_ctrl", {busy, done, err, bus_req, bus_we}, 5'b00000);
    chk("rr_rdata", read_data, 32'h0);
    chk("rr_addr", bus_addr, 32'h0);
    chk("rr_wdata", bus_wdata, 32'h0);
    tick(); tick();
    chk("rr_req_cycles", reqCnt - r0, 2);
    chk("rr_no_pulse", (doneCnt - d0) + (errCnt - e0), 0);

    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
